// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point MDC FFT.
// Stage depths are shared by the controller and every commutator.
package fft_pkg;

  localparam int FFT_N  = 32;
  localparam int DATA_W = 16;

  localparam int STAGE_DEPTH0 = 16;
  localparam int STAGE_DEPTH1 = 8;
  localparam int STAGE_DEPTH2 = 4;
  localparam int STAGE_DEPTH3 = 2;
  localparam int STAGE_DEPTH4 = 1;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } complex_t;

  function automatic int stage_depth(input int s);
    return (FFT_N / 2) >> s;
  endfunction

endpackage

// File: rtl/mdc_delay_line.sv
// Complex shift register, DEPTH samples long.
// Cleared by reset only when MDC_COM_DELAY_CLR_EN is defined.
module mdc_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [2*DATA_W-1:0] i_d,
  output logic [2*DATA_W-1:0] o_d
);
  import fft_pkg::*;

  logic [2*DATA_W-1:0] r_sr [DEPTH];

`ifdef MDC_COM_DELAY_CLR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++)
        r_sr[i] <= r_sr[i-1];
    end
  end
`else
  // No reset here so the chain can map onto SRL primitives.
  logic w_unused_rst;
  assign w_unused_rst = i_rst;

  always_ff @(posedge i_clk) begin
    r_sr[0] <= i_d;
    for (int i = 1; i < DEPTH; i++)
      r_sr[i] <= r_sr[i-1];
  end
`endif

  assign o_d = r_sr[DEPTH-1];

endmodule

// File: rtl/mdc_commutator.sv
// Delay-switch-delay commutator between MDC butterfly stages.
// Optional MDC_COM_DELAY_CLR_EN: reset also clears both delay lines.
module mdc_commutator #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din_top_re,
  input  logic signed [DATA_W-1:0] din_top_im,
  input  logic signed [DATA_W-1:0] din_bot_re,
  input  logic signed [DATA_W-1:0] din_bot_im,
  output logic signed [DATA_W-1:0] dout_top_re,
  output logic signed [DATA_W-1:0] dout_top_im,
  output logic signed [DATA_W-1:0] dout_bot_re,
  output logic signed [DATA_W-1:0] dout_bot_im,
  output logic                     out_valid
);
  import fft_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(DEPTH + 2);
  localparam int DW = 2 * DATA_W;

  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_fill;
  logic          r_valid;
  logic [DW-1:0] r_dout_top;
  logic [DW-1:0] r_dout_bot;

  logic [DW-1:0] w_din_top;
  logic [DW-1:0] w_din_bot;
  logic [DW-1:0] w_dl1;
  logic [DW-1:0] w_dl2;
  logic [DW-1:0] w_sw_top;
  logic [DW-1:0] w_sw_bot;
  logic          w_sel;

  assign w_din_top = {din_top_re, din_top_im};
  assign w_din_bot = {din_bot_re, din_bot_im};
  assign w_sel     = r_cnt[CW-1];

  mdc_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dl1 (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_din_top),
    .o_d   (w_dl1)
  );

  always_comb begin
    w_sw_top = w_dl1;
    w_sw_bot = w_din_bot;
    if (w_sel) begin
      w_sw_top = w_din_bot;
      w_sw_bot = w_dl1;
    end
  end

  mdc_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dl2 (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_sw_bot),
    .o_d   (w_dl2)
  );

  // cnt wraps naturally at 2*DEPTH; its MSB is the switch phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_cnt   <= r_cnt + 1'b1;
      if (r_fill != FW'(DEPTH + 1))
        r_fill <= r_fill + 1'b1;
      r_valid <= (r_fill >= FW'(DEPTH));
    end else begin
      r_cnt   <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_top <= '0;
      r_dout_bot <= '0;
    end else begin
      r_dout_top <= w_sw_top;
      r_dout_bot <= w_dl2;
    end
  end

  assign dout_top_re = r_dout_top[DW-1:DATA_W];
  assign dout_top_im = r_dout_top[DATA_W-1:0];
  assign dout_bot_re = r_dout_bot[DW-1:DATA_W];
  assign dout_bot_im = r_dout_bot[DATA_W-1:0];
  assign out_valid   = r_valid;

endmodule

// File: tb/tb_mdc_commutator.sv
// Directed bench for mdc_commutator across DEPTH = 4, 1, 8, 16, 2.
// Cycle k: inputs applied before edge k; outputs seen in cycle k come from edge k-1.
module tb_mdc_commutator;

  localparam int NDUT = 5;
  localparam int DEP [NDUT] = '{4, 1, 8, 16, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] dtr, dti, dbr, dbi;
  logic signed [15:0] otr [NDUT];
  logic signed [15:0] oti [NDUT];
  logic signed [15:0] obr [NDUT];
  logic signed [15:0] obi [NDUT];
  logic               ov  [NDUT];
  logic               rst_v [NDUT];
  logic               en_v  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mdc_commutator #(
      .DATA_W (16),
      .DEPTH  (DEP[g])
    ) u_dut (
      .clk         (clk),
      .rst         (rst_v[g]),
      .en          (en_v[g]),
      .din_top_re  (dtr),
      .din_top_im  (dti),
      .din_bot_re  (dbr),
      .din_bot_im  (dbi),
      .dout_top_re (otr[g]),
      .dout_top_im (oti[g]),
      .dout_bot_re (obr[g]),
      .dout_bot_im (obi[g]),
      .out_valid   (ov[g])
    );
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit has_data;
    int top;
    int bot;
    bit vld;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_seq(input int k);
    dtr = 16'(k);
    dti = 16'(-k);
    dbr = 16'(100 + k);
    dbi = 16'(-(100 + k));
  endtask

  task automatic rst_dut(input int d);
    rst_v[d] = 1'b1;
    en_v[d]  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      dtr = 16'($urandom);
      dti = 16'($urandom);
      dbr = 16'($urandom);
      dbi = 16'($urandom);
      tick();
      if (d == 0) begin
        chk($sformatf("rst%0d valid", i), int'(ov[d]), 0);
        chk($sformatf("rst%0d top_re", i), int'(otr[d]), 0);
        chk($sformatf("rst%0d top_im", i), int'(oti[d]), 0);
        chk($sformatf("rst%0d bot_re", i), int'(obr[d]), 0);
        chk($sformatf("rst%0d bot_im", i), int'(obi[d]), 0);
      end
    end
    rst_v[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      rst_v[i] = 1'b0;
      en_v[i]  = 1'b0;
    end
    dtr = '0; dti = '0; dbr = '0; dbi = '0;

    for (int c = 0; c < 21; c++)
      tbl[c] = '{has_data: 1'b0, top: 0, bot: 0, vld: (c >= 5)};
    tbl[5]  = '{1'b1, 104, 100, 1'b1};
    tbl[6]  = '{1'b1, 105, 101, 1'b1};
    tbl[7]  = '{1'b1, 106, 102, 1'b1};
    tbl[8]  = '{1'b1, 107, 103, 1'b1};
    tbl[9]  = '{1'b1,   4,   0, 1'b1};
    tbl[10] = '{1'b1,   5,   1, 1'b1};
    tbl[11] = '{1'b1,   6,   2, 1'b1};
    tbl[12] = '{1'b1,   7,   3, 1'b1};
    tbl[13] = '{1'b1, 112, 108, 1'b1};
    tbl[14] = '{1'b1, 113, 109, 1'b1};
    tbl[15] = '{1'b1, 114, 110, 1'b1};
    tbl[16] = '{1'b1, 115, 111, 1'b1};
    tbl[17] = '{1'b1,  12,   8, 1'b1};
    tbl[18] = '{1'b1,  13,   9, 1'b1};
    tbl[19] = '{1'b1,  14,  10, 1'b1};
    tbl[20] = '{1'b1,  15,  11, 1'b1};

    @(negedge clk);

    // DEPTH=4: reset then ordering/valid table
    rst_dut(0);
    for (int k = 0; k < 21; k++) begin
      drive_seq(k);
      chk($sformatf("d4 c%0d valid", k), int'(ov[0]), int'(tbl[k].vld));
      if (tbl[k].has_data) begin
        chk($sformatf("d4 c%0d top_re", k), int'(otr[0]), tbl[k].top);
        chk($sformatf("d4 c%0d top_im", k), int'(oti[0]), -tbl[k].top);
        chk($sformatf("d4 c%0d bot_re", k), int'(obr[0]), tbl[k].bot);
        chk($sformatf("d4 c%0d bot_im", k), int'(obi[0]), -tbl[k].bot);
      end
      tick();
    end

`ifdef MDC_COM_DELAY_CLR_EN
    rst_dut(0);
    for (int k = 0; k <= 4; k++) begin
      dtr = '0; dti = '0; dbr = '0; dbi = '0;
      chk($sformatf("clr c%0d top_re", k), int'(otr[0]), 0);
      chk($sformatf("clr c%0d bot_re", k), int'(obr[0]), 0);
      tick();
    end
`endif

    // DEPTH=1 valid timing
    rst_dut(1);
    for (int k = 0; k <= 2; k++) begin
      drive_seq(k);
      if (k >= 1)
        chk($sformatf("d1 c%0d valid", k), int'(ov[1]), (k >= 2) ? 1 : 0);
      tick();
    end

    // DEPTH=8: en drop at cycle 20 for 3 cycles
    rst_dut(2);
    for (int k = 0; k <= 32; k++) begin
      drive_seq(k);
      en_v[2] = !(k >= 20 && k <= 22);
      if (k == 20) chk("d8 c20 valid", int'(ov[2]), 1);
      if (k == 21) chk("d8 c21 valid", int'(ov[2]), 0);
      if (k == 28) chk("d8 c28 top_re", int'(otr[2]), 19);
      if (k == 31) chk("d8 c31 valid", int'(ov[2]), 0);
      if (k == 32) begin
        chk("d8 c32 valid", int'(ov[2]), 1);
        chk("d8 c32 top_re", int'(otr[2]), 131);
      end
      tick();
    end

    // DEPTH=16: rst pulse at cycle 40 while en stays high
    rst_dut(3);
    for (int k = 0; k <= 58; k++) begin
      drive_seq(k);
      rst_v[3] = (k == 40);
      if (k == 40) chk("d16 c40 valid", int'(ov[3]), 1);
      if (k == 41) begin
        chk("d16 c41 valid", int'(ov[3]), 0);
        chk("d16 c41 top_re", int'(otr[3]), 0);
        chk("d16 c41 bot_re", int'(obr[3]), 0);
      end
      if (k == 57) chk("d16 c57 valid", int'(ov[3]), 0);
      if (k == 58) begin
        chk("d16 c58 valid", int'(ov[3]), 1);
        chk("d16 c58 top_re", int'(otr[3]), 157);
      end
      tick();
    end
    rst_v[3] = 1'b0;

    // DEPTH=2: extreme values pass bit-exact
    rst_dut(4);
    for (int k = 0; k <= 4; k++) begin
      dtr = 16'sh8000; dti = 16'sh7fff;
      dbr = 16'sh8000; dbi = 16'sh7fff;
      if (k >= 3) begin
        chk($sformatf("d2 c%0d top_re", k), int'(otr[4]), -32768);
        chk($sformatf("d2 c%0d top_im", k), int'(oti[4]), 32767);
        chk($sformatf("d2 c%0d bot_re", k), int'(obr[4]), -32768);
        chk($sformatf("d2 c%0d bot_im", k), int'(obi[4]), 32767);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdc_commutator.md
Name: mdc_commutator

Overview:
- Delay-switch-delay commutator between two radix-2 butterfly stages of the 32-point MDC FFT; one instance per stage, DEPTH = 16, 8, 4, 2, 1.
- Reorders the two parallel complex streams so that the next butterfly receives samples spaced DEPTH apart.
- Consumes one controller enable flag (stage COM flag) as `en`; everything downstream is sequenced by this block's `out_valid`.

Parameters:
DATA_W, 16, signed width of each real/imag component
DEPTH, 16, delay-line length and switch half-period in samples; power of two, 1..16

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  stage enable from controller; level, held high while streaming
din_top_re  input  DATA_W  upper-path input, real
din_top_im  input  DATA_W  upper-path input, imag
din_bot_re  input  DATA_W  lower-path input, real
din_bot_im  input  DATA_W  lower-path input, imag
dout_top_re  output  DATA_W  upper-path output, real
dout_top_im  output  DATA_W  upper-path output, imag
dout_bot_re  output  DATA_W  lower-path output, real
dout_bot_im  output  DATA_W  lower-path output, imag
out_valid  output  1  output pair is meaningful

Behaviour:
- Single clock `clk`. Reset is synchronous, active-high, on `rst`: all outputs 0, `cnt` 0, `fill` 0, `out_valid` 0.
- Structure: DL1 (DEPTH complex regs) on the top input -> 2x2 switch -> DL2 (DEPTH regs) on the switch bottom leg -> output registers.
- Both delay lines shift every cycle, independent of `en`. `dl1_out` = `din_top` from DEPTH cycles earlier.
- Counter `cnt`: width $clog2(DEPTH)+1.
  - If `en`=1: `cnt` <= (`cnt`+1) mod 2*DEPTH.
  - If `en`=0: `cnt` <= 0.
  - `sel` = `cnt` MSB (combinational from current `cnt`). DEPTH=1 gives 1-bit `cnt`; `sel` toggles every cycle.
- Switch, combinational:
  - `sel`=0: `sw_top` = `dl1_out`, `sw_bot` = `din_bot`.
  - `sel`=1: `sw_top` = `din_bot`, `sw_bot` = `dl1_out`.
- Outputs, registered: `dout_top` <= `sw_top`; `dout_bot` <= DL2 tail (`sw_bot` from DEPTH cycles earlier).
- Latency: top input to `dout_top` is DEPTH+1 cycles; bottom input to `dout_bot` is DEPTH+1 cycles.
- No arithmetic; data passes bit-exact, no width change.
- `fill` counter, saturating at DEPTH+1:
  - Increments on each edge sampling `en`=1; cleared when `en`=0.
  - `out_valid` rises at the edge that samples `en` high for the (DEPTH+1)-th consecutive time.
  - `out_valid` falls at the first edge sampling `en`=0.
- `en` drop mid-stream: `cnt`, `fill`, `out_valid` return to 0 next edge; data path keeps shifting; re-assertion restarts the phase from `sel`=0.
- `rst` mid-operation: overrides `en`; state as at reset on the next edge.
- `rst` and `en` asserted together: reset wins.

Optional Feature:
Macro MDC_COM_DELAY_CLR_EN.
- Defined: `rst` also clears every DL1/DL2 register, so outputs are 0 until real data arrives.
- Undefined: delay lines have no reset, which allows shift-register/SRL inference; `dout_*` registers, `cnt`, `fill` and `out_valid` are still reset. Pre-fill output values are undefined but masked by `out_valid`=0.

Decomposition:
- Shared package `fft_pkg`:
  - FFT_N=32, DATA_W default.
  - `complex_t` typedef (signed re/im).
  - STAGE_DEPTH constants 16/8/4/2/1, reused by the controller and all commutator instances.
- One sub-module `mdc_delay_line` (parameters DATA_W, DEPTH; complex shift register; reset honoured only under MDC_COM_DELAY_CLR_EN), instantiated twice.

Test Plan:
- Reset: hold `rst`=1 for 3 cycles with random inputs, `en`=1 -> all `dout_*`=0, `out_valid`=0; with MDC_COM_DELAY_CLR_EN, `dout_*` stay 0 through cycle DEPTH after release when inputs are 0.
- Ordering, DEPTH=4, `en`=1 from cycle 0, `din_top`=(k,-k), `din_bot`=(100+k,-(100+k)) at cycle k:
  - Cycles 5..8: `dout_top` re=104..107, `dout_bot` re=100..103.
  - Cycles 9..12: `dout_top` re=4..7, `dout_bot` re=0..3.
  - Pattern repeats every 8 cycles.
- Valid timing, DEPTH=4: `out_valid`=0 in cycles 0..4, 1 from cycle 5; for DEPTH=1, `out_valid` first high in cycle 2.
- `en` drop: DEPTH=8, drop `en` at cycle 20 for 3 cycles -> `out_valid`=0 at cycle 21; after re-assertion at cycle 23, `sel`=0 at cycle 23, `out_valid` high again at cycle 32.
- `rst` mid-stream: DEPTH=16, assert `rst` at cycle 40 with `en`=1 -> cycle 41: `out_valid`=0, `cnt`=0, outputs 0; with `en` still high, `out_valid` returns at cycle 58.
- Sign/width: DEPTH=2, inputs re=-32768, im=32767 -> identical values at outputs after 3 cycles, no truncation.
